// File: rtl/afe_seq_ctrl.sv
// afe_seq_ctrl
// Transaction sequencer in front of the AFE4490 SPI master. After reset it
// writes a fixed initialisation table, then for every ADC_RDY rising edge it
// enables SPI register reads, fetches the LED/ambient result registers,
// disables reads again and publishes the new sample set with a one-cycle
// strobe.
//
// Parameters
//   TIMEOUT        clock cycles allowed from o_spi_dv to i_spi_done (>= 2)
//
// Build option
//   AFE_DIFF_READ_EN  when defined, the batch also reads 0x2E/0x2F and drives
//                     o_led2_diff / o_led1_diff; otherwise those ports are 0.
//
// Ports
//   i_clk, i_rst_n                      clock, asynchronous active-low reset
//   i_adc_rdy                           AFE ADC_RDY pin (asynchronous)
//   o_spi_addr/o_spi_wr_data/o_spi_rd_wr  request to SPI master (1 = read)
//   o_spi_dv                            one-cycle request strobe
//   i_spi_done, i_spi_rd_data           completion strobe and read data
//   o_led2 .. o_aled1, o_*_diff         latest published results
//   o_sample_valid                      one-cycle strobe: results updated
//   o_init_done                         init table has been written
//   o_overrun                           sticky: ADC_RDY edge while busy
//   o_err                               sticky: SPI transaction timed out

module afe_seq_ctrl #(
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_adc_rdy,
   output logic [7:0]  o_spi_addr,
   output logic [23:0] o_spi_wr_data,
   output logic        o_spi_rd_wr,
   output logic        o_spi_dv,
   input  logic        i_spi_done,
   input  logic [23:0] i_spi_rd_data,
   output logic [23:0] o_led2,
   output logic [23:0] o_aled2,
   output logic [23:0] o_led1,
   output logic [23:0] o_aled1,
   output logic [23:0] o_led2_diff,
   output logic [23:0] o_led1_diff,
   output logic        o_sample_valid,
   output logic        o_init_done,
   output logic        o_overrun,
   output logic        o_err
);

`ifdef AFE_DIFF_READ_EN
   localparam int NUM_RD = 6;
`else
   localparam int NUM_RD = 4;
`endif
   localparam int NUM_INIT = 4;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_RESET,
      S_INIT_REQ,
      S_INIT_WAIT,
      S_ARM,
      S_REN_REQ,
      S_REN_WAIT,
      S_RD_REQ,
      S_RD_WAIT,
      S_RDIS_REQ,
      S_RDIS_WAIT,
      S_PUBLISH
   } state_t;

   state_t          state, state_next;
   logic [2:0]      idx, idx_next;
   logic [CW-1:0]   wait_cnt;
   logic            rdy_meta, rdy_sync, rdy_prev, rdy_edge;
   logic            init_done, overrun, err;
   logic            is_wait, timed_out, capture, publish, set_init_done;
   logic [23:0]     shadow [NUM_RD];
   logic [23:0]     result [NUM_RD];

   function automatic logic [7:0] init_addr(input logic [2:0] i);
      case (i)
         3'd0:    return 8'h00;
         3'd1:    return 8'h1D;
         3'd2:    return 8'h1E;
         3'd3:    return 8'h23;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [23:0] init_data(input logic [2:0] i);
      case (i)
         3'd0:    return 24'h000000;
         3'd1:    return 24'h009C3F;
         3'd2:    return 24'h000101;
         3'd3:    return 24'h020100;
         default: return 24'h000000;
      endcase
   endfunction

   // ADC_RDY comes straight from the AFE pin, so it passes through two flops
   // before use; a third flop gives the rising-edge detector its history.
   // This runs in every state so edges outside ARM can be flagged.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rdy_meta <= 1'b0;
         rdy_sync <= 1'b0;
         rdy_prev <= 1'b0;
      end else begin
         rdy_meta <= i_adc_rdy;
         rdy_sync <= rdy_meta;
         rdy_prev <= rdy_sync;
      end
   end

   assign rdy_edge = rdy_sync & ~rdy_prev;

   // Next-state and SPI request decode. The request fields are a pure
   // function of state and index, so they hold from the REQ cycle through
   // the cycle in which done arrives (the SPI master samples rd_wr live).
   // A timeout in any WAIT state overrides the normal transition.
   always_comb begin
      state_next    = state;
      idx_next      = idx;
      o_spi_addr    = 8'h00;
      o_spi_wr_data = 24'h000000;
      o_spi_rd_wr   = 1'b0;
      o_spi_dv      = 1'b0;
      capture       = 1'b0;
      publish       = 1'b0;
      set_init_done = 1'b0;
      is_wait       = state inside {S_INIT_WAIT, S_REN_WAIT, S_RD_WAIT, S_RDIS_WAIT};
      timed_out     = is_wait && !i_spi_done && (wait_cnt == TO_LAST);

      case (state)
         S_RESET: begin
            idx_next   = 3'd0;
            state_next = S_INIT_REQ;
         end
         S_INIT_REQ: begin
            o_spi_addr    = init_addr(idx);
            o_spi_wr_data = init_data(idx);
            o_spi_dv      = 1'b1;
            state_next    = S_INIT_WAIT;
         end
         S_INIT_WAIT: begin
            o_spi_addr    = init_addr(idx);
            o_spi_wr_data = init_data(idx);
            if (i_spi_done) begin
               if (idx == 3'(NUM_INIT - 1)) begin
                  set_init_done = 1'b1;
                  idx_next      = 3'd0;
                  state_next    = S_ARM;
               end else begin
                  idx_next   = idx + 3'd1;
                  state_next = S_INIT_REQ;
               end
            end
         end
         S_ARM: begin
            if (rdy_edge) begin
               state_next = S_REN_REQ;
            end
         end
         S_REN_REQ: begin
            o_spi_wr_data = 24'h000001;
            o_spi_dv      = 1'b1;
            state_next    = S_REN_WAIT;
         end
         S_REN_WAIT: begin
            o_spi_wr_data = 24'h000001;
            if (i_spi_done) begin
               idx_next   = 3'd0;
               state_next = S_RD_REQ;
            end
         end
         S_RD_REQ: begin
            o_spi_addr  = 8'h2A + {5'b00000, idx};
            o_spi_rd_wr = 1'b1;
            o_spi_dv    = 1'b1;
            state_next  = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            o_spi_addr  = 8'h2A + {5'b00000, idx};
            o_spi_rd_wr = 1'b1;
            if (i_spi_done) begin
               capture = 1'b1;
               if (idx == 3'(NUM_RD - 1)) begin
                  idx_next   = 3'd0;
                  state_next = S_RDIS_REQ;
               end else begin
                  idx_next   = idx + 3'd1;
                  state_next = S_RD_REQ;
               end
            end
         end
         S_RDIS_REQ: begin
            o_spi_dv   = 1'b1;
            state_next = S_RDIS_WAIT;
         end
         S_RDIS_WAIT: begin
            if (i_spi_done) begin
               publish    = 1'b1;
               state_next = S_PUBLISH;
            end
         end
         S_PUBLISH: begin
            state_next = S_ARM;
         end
         default: begin
            state_next = S_RESET;
         end
      endcase

      // A stuck transaction abandons the batch; before init completes the
      // whole table is retried from the first entry.
      if (timed_out) begin
         idx_next   = 3'd0;
         state_next = init_done ? S_ARM : S_INIT_REQ;
      end
   end

   // State, timeout counter, sticky flags and data registers. The counter
   // holds the number of cycles since the request strobe (the REQ cycle
   // counts as one). Results load on the edge into PUBLISH so they are
   // already updated while o_sample_valid is high.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= S_RESET;
         idx       <= 3'd0;
         wait_cnt  <= '0;
         init_done <= 1'b0;
         overrun   <= 1'b0;
         err       <= 1'b0;
         for (int i = 0; i < NUM_RD; i++) begin
            shadow[i] <= 24'h000000;
            result[i] <= 24'h000000;
         end
      end else begin
         state <= state_next;
         idx   <= idx_next;
         if (o_spi_dv) begin
            wait_cnt <= CW'(1);
         end else if (is_wait) begin
            wait_cnt <= wait_cnt + CW'(1);
         end
         if (set_init_done) begin
            init_done <= 1'b1;
         end
         if (rdy_edge && (state != S_ARM)) begin
            overrun <= 1'b1;
         end
         if (timed_out) begin
            err <= 1'b1;
         end
         for (int i = 0; i < NUM_RD; i++) begin
            if (capture && (idx == 3'(i))) begin
               shadow[i] <= i_spi_rd_data;
            end
            if (publish) begin
               result[i] <= shadow[i];
            end
         end
      end
   end

   assign o_sample_valid = (state == S_PUBLISH);
   assign o_init_done    = init_done;
   assign o_overrun      = overrun;
   assign o_err          = err;
   assign o_led2         = result[0];
   assign o_aled2        = result[1];
   assign o_led1         = result[2];
   assign o_aled1        = result[3];
`ifdef AFE_DIFF_READ_EN
   assign o_led2_diff    = result[4];
   assign o_led1_diff    = result[5];
`else
   assign o_led2_diff    = 24'h000000;
   assign o_led1_diff    = 24'h000000;
`endif

endmodule
